// File: rtl/fib_pkg.sv
// Shared types and defaults for the word-parallel Fibonacci sequence generator.
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 8;
  localparam int unsigned FIB_IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;

  // A start is honoured only when no sequence is streaming, and never alongside clear.
  function automatic logic fib_start_ok(input fib_state_t st, input logic start,
                                        input logic clear);
    return start && !clear && (st != RUN);
  endfunction

endpackage

// File: rtl/fib_adder.sv
// WIDTH-bit ripple-carry adder built from full-adder cells, with carry out.
module fib_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Streams T0=seed0, T1=seed1, Tk=Tk-1+Tk-2 mod 2^WIDTH over valid/ready, with
// per-term and sticky overflow tracking and optional stop-on-overflow.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH       = FIB_WIDTH,
  parameter int unsigned IDX_W       = FIB_IDX_W,
  parameter bit          STOP_ON_OVF = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] n_target,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_ovf,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  fib_state_t state, state_next;

  logic [WIDTH-1:0] a, b;
  logic             a_ovf, b_ovf;
  logic [IDX_W-1:0] idx, last;
  logic             ovf_sticky;

  logic [WIDTH-1:0] sum;
  logic             carry_out;

  logic load, advance, finish, stop_ovf, hs;

  fib_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (carry_out)
  );

  assign hs = (state == RUN) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    stop_ovf   = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (fib_start_ok(state, start, clear)) begin
            state_next = RUN;
            load       = 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            if (idx == last) begin
              state_next = DONE;
              finish     = 1'b1;
            end else if (STOP_ON_OVF && b_ovf) begin
              // The next term is already tainted: end here so it is never presented.
              state_next = DONE;
              stop_ovf   = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a          <= '0;
      b          <= '0;
      a_ovf      <= 1'b0;
      b_ovf      <= 1'b0;
      idx        <= '0;
      last       <= '0;
      ovf_sticky <= 1'b0;
    end else if (clear) begin
      a          <= '0;
      b          <= '0;
      a_ovf      <= 1'b0;
      b_ovf      <= 1'b0;
      idx        <= '0;
      last       <= '0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      a          <= seed0;
      b          <= seed1;
      a_ovf      <= 1'b0;
      b_ovf      <= 1'b0;
      idx        <= '0;
      last       <= n_target;
      ovf_sticky <= 1'b0;
    end else if (advance) begin
      a          <= b;
      a_ovf      <= b_ovf;
      b          <= sum;
      b_ovf      <= a_ovf | b_ovf | carry_out;
      idx        <= idx + IDX_W'(1);
      ovf_sticky <= ovf_sticky | a_ovf;
    end else if (finish) begin
      ovf_sticky <= ovf_sticky | a_ovf;
    end else if (stop_ovf) begin
      ovf_sticky <= 1'b1;
    end
  end

  // a/idx are left untouched on termination, so DONE keeps showing the last term.
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign out_data  = a;
  assign out_index = idx;
  assign out_ovf   = (state == RUN) && a_ovf;
  assign overflow  = ovf_sticky;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench: two generators (wrap and stop-on-overflow) driven in
// parallel and compared against an unbounded-integer Fibonacci model.
module tb_fib_seq_gen;

  logic       clk = 1'b0;
  logic       reset, start, clear, out_ready;
  logic [7:0] seed0, seed1;
  logic [5:0] n_target;

  logic [1:0] ov, oovf, oof, obusy, odone;
  logic [7:0] od [2];
  logic [5:0] oi [2];

  int errors = 0;
  int checks = 0;

  longint unsigned exp_data [64];
  bit              exp_ovf  [64];
  int              n_emit   [2];
  bit              exp_of   [2];

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(8), .IDX_W(6), .STOP_ON_OVF(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .seed0(seed0), .seed1(seed1), .n_target(n_target), .out_ready(out_ready),
    .out_valid(ov[0]), .out_data(od[0]), .out_index(oi[0]), .out_ovf(oovf[0]),
    .overflow(oof[0]), .busy(obusy[0]), .done(odone[0])
  );

  fib_seq_gen #(.WIDTH(8), .IDX_W(6), .STOP_ON_OVF(1'b1)) dut_stop (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .seed0(seed0), .seed1(seed1), .n_target(n_target), .out_ready(out_ready),
    .out_valid(ov[1]), .out_data(od[1]), .out_index(oi[1]), .out_ovf(oovf[1]),
    .overflow(oof[1]), .busy(obusy[1]), .done(odone[1])
  );

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // True term values grow monotonically from T2 on, so a term is overflowed
  // exactly when its unbounded value no longer fits in 8 bits.
  task automatic build(input int s0, input int s1, input int nt);
    longint unsigned t [64];
    int first_ovf;
    t[0] = longint'(s0);
    t[1] = longint'(s1);
    exp_data[0] = t[0] % 256;
    exp_data[1] = t[1] % 256;
    for (int k = 2; k < 64; k++) begin
      t[k] = t[k-1] + t[k-2];
      if (t[k] > (64'd1 << 40)) t[k] = 64'd1 << 40;
      exp_data[k] = (exp_data[k-1] + exp_data[k-2]) % 256;
    end
    first_ovf = 64;
    for (int k = 0; k < 64; k++) begin
      exp_ovf[k] = (t[k] >= 256);
      if (exp_ovf[k] && first_ovf == 64) first_ovf = k;
    end
    n_emit[0] = nt + 1;
    n_emit[1] = (first_ovf <= nt) ? first_ovf : nt + 1;
    exp_of[0] = (first_ovf <= nt);
    exp_of[1] = (first_ovf <= nt);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_valid%0d", tag, d), ov[d], 0);
      check($sformatf("%s_data%0d", tag, d), od[d], 0);
      check($sformatf("%s_index%0d", tag, d), oi[d], 0);
      check($sformatf("%s_ovf%0d", tag, d), oovf[d], 0);
      check($sformatf("%s_overflow%0d", tag, d), oof[d], 0);
      check($sformatf("%s_busy%0d", tag, d), obusy[d], 0);
      check($sformatf("%s_done%0d", tag, d), odone[d], 0);
    end
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random. *_at = -1 disables.
  task automatic run(input int s0, input int s1, input int nt, input int rmode,
                     input int start_at, input int clear_at, input int reset_at);
    int pos [2];
    bit fin [2];
    int cyc;
    bit aborted;
    bit do_clear;
    build(s0, s1, nt);
    pos[0] = 0; pos[1] = 0; fin[0] = 1'b0; fin[1] = 1'b0;
    aborted = 1'b0;
    seed0 = 8'(s0); seed1 = 8'(s1); n_target = 6'(nt); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed0 = 8'($urandom); seed1 = 8'($urandom); n_target = 6'($urandom);
    cyc = 0;
    while (!(fin[0] && fin[1]) && !aborted && cyc < 400) begin
      if (rmode == 0)      out_ready = 1'b1;
      else if (rmode == 1) out_ready = (cyc % 3 == 0);
      else                 out_ready = 1'($urandom_range(0, 1));
      do_clear = 1'b0;
      if (reset_at >= 0 && pos[0] == reset_at && ov[0]) begin
        #2 reset = 1'b1;
        #1 check_zero("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("rst_hold");
        aborted = 1'b1;
      end else begin
        if (start_at >= 0 && pos[0] == start_at && ov[0]) begin
          start = 1'b1; seed0 = 8'd77; seed1 = 8'd99; n_target = 6'd2;
        end
        if (clear_at >= 0 && pos[0] == clear_at && ov[0]) begin
          clear = 1'b1;
          do_clear = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
          if (!fin[d]) begin
            if (pos[d] < n_emit[d]) begin
              check($sformatf("valid%0d_k%0d", d, pos[d]), ov[d], 1);
              check($sformatf("busy%0d_k%0d", d, pos[d]), obusy[d], 1);
              if (ov[d]) begin
                check($sformatf("data%0d_k%0d", d, pos[d]), od[d], exp_data[pos[d]]);
                check($sformatf("index%0d_k%0d", d, pos[d]), oi[d], longint'(pos[d]));
                check($sformatf("ovf%0d_k%0d", d, pos[d]), oovf[d], exp_ovf[pos[d]]);
                if (out_ready) pos[d]++;
              end
            end else begin
              check($sformatf("end_valid%0d", d), ov[d], 0);
              check($sformatf("end_done%0d", d), odone[d], 1);
              check($sformatf("end_overflow%0d", d), oof[d], exp_of[d]);
              fin[d] = 1'b1;
            end
          end
        end
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        if (do_clear) begin
          clear = 1'b0;
          for (int d = 0; d < 2; d++) begin
            check($sformatf("clr_valid%0d", d), ov[d], 0);
            check($sformatf("clr_busy%0d", d), obusy[d], 0);
            check($sformatf("clr_done%0d", d), odone[d], 0);
          end
          aborted = 1'b1;
        end
      end
    end
    if (!aborted && !(fin[0] && fin[1])) check("timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; out_ready = 1'b0;
    seed0 = '0; seed1 = '0; n_target = '0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run(0, 1, 13, 0, -1, -1, -1);
    run(0, 1, 14, 0, -1, -1, -1);
    run(0, 1, 15, 0, -1, -1, -1);
    run(2, 1, 5, 1, -1, -1, -1);
    run(0, 1, 9, 0, -1, -1, 4);
    run(0, 1, 0, 0, -1, -1, -1);
    run(0, 1, 20, 0, 3, 5, -1);
    run(0, 1, 0, 2, -1, -1, -1);
    for (int r = 0; r < 10; r++)
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), -1, -1, -1);
    run(255, 255, 63, 2, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
